// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CISC core: bus widths, the extension-word
// opcode marker and the instruction fetch state encoding.
package cpu_pkg;

  localparam int AW = 5;
  localparam int DW = 16;

  localparam logic [3:0]    EXT_CODE = 4'h8;
  localparam logic [AW-1:0] PC_ONE   = 5'd1;

  typedef enum logic [1:0] {
    S_ADDR = 2'd0,
    S_OP   = 2'd1,
    S_EXT  = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  // True when an opcode word announces a following immediate word.
  function automatic logic has_ext_word(input logic [DW-1:0] word);
    return (word[3:0] == EXT_CODE);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: memory read port, redirect input and the
// instruction valid/ready handshake towards decode.
interface instr_fetch_if;
  import cpu_pkg::*;

  logic [AW-1:0] eab;
  logic [DW-1:0] dout_m;
  logic          mem_busy;
  logic          bus_free;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic [DW-1:0] ir;
  logic [DW-1:0] imm;
  logic          ext;
  logic [AW-1:0] ins_pc;
  logic          ins_valid;
  logic          ins_ready;

  modport master (
    input  dout_m, mem_busy, redirect, redirect_addr, ins_ready,
    output eab, bus_free, ir, imm, ext, ins_pc, ins_valid
  );

  modport slave (
    output dout_m, mem_busy, redirect, redirect_addr, ins_ready,
    input  eab, bus_free, ir, imm, ext, ins_pc, ins_valid
  );

endinterface

// File: rtl/fetch_pc.sv
// Program counter: redirect load has priority over increment; wraps mod 2^AW.
module fetch_pc
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic          inc,
  output logic [AW-1:0] pc
);

  logic [AW-1:0] pc_r;

  // PC register update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= 5'd0;
    end else if (load) begin
      pc_r <= load_addr;
    end else if (inc) begin
      pc_r <= pc_r + PC_ONE;
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues addresses to the unified memory, assembles one- or
// two-word instructions and presents them to decode over valid/ready.
module instr_fetch
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  instr_fetch_if.master fif
);

  fetch_state_e  state_r;
  logic [AW-1:0] eab_r;
  logic [DW-1:0] ir_r;
  logic [DW-1:0] imm_r;
  logic          ext_r;
  logic [AW-1:0] ins_pc_r;
  logic          ins_valid_r;
  logic          bus_free_r;
  logic [AW-1:0] pc_s;
  logic          pc_inc_s;

  fetch_pc u_fetch_pc (
    .clk       (clk),
    .rst       (rst),
    .load      (fif.redirect),
    .load_addr (fif.redirect_addr),
    .inc       (pc_inc_s),
    .pc        (pc_s)
  );

  // PC advances once per captured word unless a redirect reloads it
  always_comb begin
    pc_inc_s = 1'b0;
    if (fif.redirect) begin
      pc_inc_s = 1'b0;
    end else if ((state_r == S_OP) || (state_r == S_EXT)) begin
      pc_inc_s = 1'b1;
    end else begin
      pc_inc_s = 1'b0;
    end
  end

  // Fetch sequencer with registered outputs; redirect overrides every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_ADDR;
      eab_r       <= 5'd0;
      ir_r        <= 16'd0;
      imm_r       <= 16'd0;
      ext_r       <= 1'b0;
      ins_pc_r    <= 5'd0;
      ins_valid_r <= 1'b0;
      bus_free_r  <= 1'b1;
    end else if (fif.redirect) begin
      ins_valid_r <= 1'b0;
      if (!fif.mem_busy) begin
        eab_r      <= fif.redirect_addr;
        state_r    <= S_OP;
        bus_free_r <= 1'b0;
      end else begin
        state_r    <= S_ADDR;
        bus_free_r <= 1'b1;
      end
    end else begin
      case (state_r)
        S_ADDR: begin
          if (!fif.mem_busy) begin
            eab_r      <= pc_s;
            state_r    <= S_OP;
            bus_free_r <= 1'b0;
          end
        end
        S_OP: begin
          ir_r     <= fif.dout_m;
          ins_pc_r <= pc_s;
          if (has_ext_word(fif.dout_m)) begin
            eab_r   <= pc_s + PC_ONE;
            ext_r   <= 1'b1;
            state_r <= S_EXT;
          end else begin
            imm_r       <= 16'd0;
            ext_r       <= 1'b0;
            ins_valid_r <= 1'b1;
            state_r     <= S_HOLD;
            bus_free_r  <= 1'b1;
          end
        end
        S_EXT: begin
          imm_r       <= fif.dout_m;
          ins_valid_r <= 1'b1;
          state_r     <= S_HOLD;
          bus_free_r  <= 1'b1;
        end
        S_HOLD: begin
          if (fif.ins_ready) begin
            ins_valid_r <= 1'b0;
            if (!fif.mem_busy) begin
              eab_r      <= pc_s;
              state_r    <= S_OP;
              bus_free_r <= 1'b0;
            end else begin
              state_r    <= S_ADDR;
            end
          end
        end
        default: begin
          state_r     <= S_ADDR;
          ins_valid_r <= 1'b0;
          bus_free_r  <= 1'b1;
        end
      endcase
    end
  end

  assign fif.eab       = eab_r;
  assign fif.ir        = ir_r;
  assign fif.imm       = imm_r;
  assign fif.ext       = ext_r;
  assign fif.ins_pc    = ins_pc_r;
  assign fif.ins_valid = ins_valid_r;
  assign fif.bus_free  = bus_free_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with exact latencies,
// then randomized handshake/stall/redirect traffic against an instruction-stream model.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [DW-1:0] mem [0:31];

  instr_fetch_if fif ();

  instr_fetch dut (
    .clk (clk),
    .rst (rst),
    .fif (fif)
  );

  always #5 clk = ~clk;

  // Memory returns the word at eab on every falling edge
  always @(negedge clk) fif.dout_m = mem[fif.eab];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges (the first one included) until ins_valid is seen; redirect is a one-edge pulse.
  task automatic wait_valid(input int budget, output int n);
    n = 0;
    do begin
      tick();
      fif.redirect = 1'b0;
      n++;
    end while (!fif.ins_valid && n < budget);
    check_eq("valid_seen", {63'd0, fif.ins_valid}, 64'd1);
  endtask

  task automatic check_ins(input string tag, input logic [DW-1:0] e_ir, input logic [DW-1:0] e_imm,
                           input logic e_ext, input logic [AW-1:0] e_pc);
    check_eq({tag, "_ir"},  {48'd0, fif.ir}, {48'd0, e_ir});
    check_eq({tag, "_imm"}, {48'd0, fif.imm}, {48'd0, e_imm});
    check_eq({tag, "_ext"}, {63'd0, fif.ext}, {63'd0, e_ext});
    check_eq({tag, "_pc"},  {59'd0, fif.ins_pc}, {59'd0, e_pc});
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"}, {fif.eab, fif.ir, fif.imm, fif.ext, fif.ins_pc, fif.ins_valid}, 64'd0);
  endtask

  // Reference: the instruction that starting address p decodes to, packed {ir, imm, ext, pc}
  function automatic logic [37:0] ref_ins(input int p);
    logic [DW-1:0] op;
    op = mem[p];
    if (op[3:0] == 4'h8) return {op, mem[(p + 1) % 32], 1'b1, 5'(p)};
    else                 return {op, 16'h0000, 1'b0, 5'(p)};
  endfunction

  initial begin
    int n;
    int p;
    int accepted;
    logic [37:0] exp_ins;
    logic [DW-1:0] w;

    fif.mem_busy = 1'b0;
    fif.redirect = 1'b0;
    fif.redirect_addr = 5'd0;
    fif.ins_ready = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 16'hA001;
    mem[0] = 16'h4497; mem[1] = 16'h0047; mem[2] = 16'h0102;
    mem[5] = 16'h04E8; mem[6] = 16'h0001; mem[7] = 16'h6419;
    mem[8] = 16'h1234; mem[12] = 16'h188C; mem[20] = 16'h3333;
    mem[31] = 16'h0008;

    // Reset state and first fetch
    tick(); tick();
    check_all_zero("reset");
    check_eq("reset_bus_free", {63'd0, fif.bus_free}, 64'd1);
    rst = 1'b0;
    fif.ins_ready = 1'b1;
    wait_valid(10, n);
    check_eq("first_latency", n, 2);
    check_ins("first", 16'h4497, 16'h0000, 1'b0, 5'd0);
    wait_valid(10, n);
    check_eq("single_thru", n, 2);
    check_ins("second", 16'h0047, 16'h0000, 1'b0, 5'd1);

    // Two-word instruction via redirect
    fif.redirect = 1'b1; fif.redirect_addr = 5'd5;
    wait_valid(10, n);
    check_eq("redir_ext_latency", n, 3);
    check_ins("two_word", 16'h04E8, 16'h0001, 1'b1, 5'd5);
    wait_valid(10, n);
    check_eq("after_ext_thru", n, 2);
    check_ins("after_ext", 16'h6419, 16'h0000, 1'b0, 5'd7);

    // Backpressure: everything frozen for 5 cycles
    fif.ins_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("hold_valid", {63'd0, fif.ins_valid}, 64'd1);
      check_ins("hold", 16'h6419, 16'h0000, 1'b0, 5'd7);
      check_eq("hold_eab", {59'd0, fif.eab}, 64'd7);
    end
    fif.ins_ready = 1'b1;
    wait_valid(10, n);
    check_eq("bp_release", n, 2);
    check_ins("bp_next", 16'h1234, 16'h0000, 1'b0, 5'd8);

    // Redirect during the extension-word fetch discards the partial instruction
    fif.redirect = 1'b1; fif.redirect_addr = 5'd5;
    tick(); fif.redirect = 1'b0;
    tick();
    check_eq("in_ext_valid", {63'd0, fif.ins_valid}, 64'd0);
    check_eq("in_ext_bus_free", {63'd0, fif.bus_free}, 64'd0);
    fif.redirect = 1'b1; fif.redirect_addr = 5'd12;
    wait_valid(10, n);
    check_eq("mid_redir_latency", n, 2);
    check_ins("mid_redir", 16'h188C, 16'h0000, 1'b0, 5'd12);
    // Redirect together with ready: held instruction is dropped, target comes next
    fif.redirect = 1'b1; fif.redirect_addr = 5'd20;
    wait_valid(10, n);
    check_eq("redir_ready_latency", n, 2);
    check_ins("redir_ready", 16'h3333, 16'h0000, 1'b0, 5'd20);

    // Wrap-around of the extension word
    fif.redirect = 1'b1; fif.redirect_addr = 5'd31;
    wait_valid(10, n);
    check_ins("wrap", 16'h0008, 16'h4497, 1'b1, 5'd31);
    wait_valid(10, n);
    check_ins("wrap_next", 16'h0047, 16'h0000, 1'b0, 5'd1);

    // Bus stall at accept
    fif.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_valid", {63'd0, fif.ins_valid}, 64'd0);
      check_eq("stall_bus_free", {63'd0, fif.bus_free}, 64'd1);
      check_eq("stall_eab", {59'd0, fif.eab}, 64'd1);
    end
    fif.mem_busy = 1'b0;
    wait_valid(10, n);
    check_eq("stall_resume_latency", n, 2);
    check_ins("stall_resume", 16'h0102, 16'h0000, 1'b0, 5'd2);

    // Asynchronous reset in the middle of a two-word fetch
    fif.redirect = 1'b1; fif.redirect_addr = 5'd5;
    tick(); fif.redirect = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    tick();
    rst = 1'b0;
    wait_valid(10, n);
    check_eq("rst_restart_latency", n, 2);
    check_ins("rst_restart", 16'h4497, 16'h0000, 1'b0, 5'd0);

    // Randomized traffic against the instruction-stream model
    rst = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      w = 16'($urandom);
      if ($urandom_range(3) == 0) w[3:0] = 4'h8;
      mem[i] = w;
    end
    rst = 1'b0;
    p = 0;
    accepted = 0;
    for (int c = 0; c < 3000; c++) begin
      fif.ins_ready = ($urandom_range(1) == 1);
      fif.mem_busy = ($urandom_range(3) == 0);
      fif.redirect = ($urandom_range(19) == 0);
      fif.redirect_addr = 5'($urandom_range(31));
      #1;
      if (fif.ins_valid) begin
        exp_ins = ref_ins(p);
        check_eq("rand_instr", {26'd0, fif.ir, fif.imm, fif.ext, fif.ins_pc}, {26'd0, exp_ins});
        if (fif.ins_ready && !fif.redirect) begin
          accepted++;
          p = (p + (exp_ins[5] ? 2 : 1)) % 32;
        end
      end
      if (fif.redirect) p = int'(fif.redirect_addr);
      tick();
    end
    check_eq("rand_progress", {63'd0, accepted > 100}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 16-bit CISC core, sitting directly upstream of the 32×16 unified memory. It drives the 5-bit memory address bus `eab`, captures the word the memory returns on `dout_m`, and assembles one- or two-word instructions. It presents each complete instruction to the decode/control stage through a valid/ready handshake, and supports PC redirect for branches and jumps.

## Interface
- `AW`, 5, address width; matches the memory depth of 32 words.
- `DW`, 16, data and instruction word width.
- `EXT_CODE`, 4'h8, value of `ir[3:0]` that marks an instruction followed by one extension (immediate) word.

- `clk`  in  1  system clock. Memory reads on negedge; this block acts on posedge.
- `rst`  in  1  reset; asynchronous, active-high.
- `dout_m`  in  DW  memory read data for the address on `eab`. Valid from the negedge after `eab` changes.
- `mem_busy`  in  1  data stage owns the memory bus. Sampled only when issuing an address.
- `redirect`  in  1  load a new PC; single-cycle pulse.
- `redirect_addr`  in  AW  target address.
- `ins_ready`  in  1  decode accepts the presented instruction.
- `eab`  out  AW  fetch address to memory (registered).
- `ir`  out  DW  opcode word.
- `imm`  out  DW  extension word; 0 for single-word instructions.
- `ext`  out  1  instruction is two-word.
- `ins_pc`  out  AW  address of the opcode word.
- `ins_valid`  out  1  `ir`/`imm`/`ext`/`ins_pc` hold a complete instruction.
- `bus_free`  out  1  fetch is not waiting on memory data (state S_ADDR or S_HOLD).

## Operation
- **Registers:** `pc` [AW], `eab`, `ir`, `imm`, `ext`, `ins_pc`, `ins_valid`, 2-bit state.
- **States:**
  - S_ADDR: if `!mem_busy`, set `eab<=pc` and go to S_OP. Otherwise stay.
  - S_OP: `ir<=dout_m`, `ins_pc<=pc`, `pc<=pc+1`.
    - If `dout_m[3:0]==EXT_CODE`: `eab<=pc+1`, `ext<=1`, go to S_EXT.
    - Otherwise: `imm<=0`, `ext<=0`, `ins_valid<=1`, go to S_HOLD.
  - S_EXT: `imm<=dout_m`, `pc<=pc+1`, `ins_valid<=1`, go to S_HOLD.
  - S_HOLD: all outputs held stable while `ins_valid && !ins_ready`. On `ins_ready`:
    - `ins_valid<=0`.
    - If `!mem_busy`: `eab<=pc`, go to S_OP.
    - If `mem_busy`: go to S_ADDR.
- **Redirect:** overrides everything, in any state.
  - Sets `pc<=redirect_addr` and `ins_valid<=0`; any partial instruction is discarded.
  - If `!mem_busy`: `eab<=redirect_addr`, go to S_OP.
  - If `mem_busy`: go to S_ADDR.
- **Redirect with `ins_ready` in the same cycle:** the redirect wins and the held instruction counts as NOT accepted.
- **PC arithmetic:** mod 2^AW; 31+1 wraps to 0. An extension word at a wrapped address is fetched normally.
- **Memory writes:** this block never writes memory and does not drive `cwrd`.
- **`mem_busy` outside S_ADDR/S_HOLD:** ignored. The data stage must honour `bus_free`.

## Timing
- **Reset:** `rst` high clears all outputs to 0 (`eab`, `ir`, `imm`, `ext`, `ins_pc`, `ins_valid`) and sets `pc=0`, state S_ADDR. This applies immediately and asynchronously, including mid-instruction.
- **Memory latency:** `eab` changes at posedge N, memory returns data at negedge N, and the block captures it at posedge N+1. Read latency is one cycle.
- **First instruction after reset release:** `ins_valid` rises after the 2nd posedge.
- **Throughput with `ins_ready` held high:** a single-word instruction takes 2 cycles; a two-word instruction takes 3.
- **Redirect:** the instruction at the target is valid 2 cycles after the redirect edge (single-word) or 3 cycles (two-word).
- **Stall:** each cycle of `mem_busy` at issue adds one cycle.

## Structure
- Shared package `cpu_pkg`:
  - `AW`/`DW` constants.
  - `EXT_CODE`.
  - fetch state enum (S_ADDR, S_OP, S_EXT, S_HOLD).
- Optional sub-module `fetch_pc`: the PC register with increment, redirect load and wrap. Everything else stays in `instr_fetch`.

## Test plan
- **Reset and first fetch.** Memory preloaded with mem[0]=4497, mem[1]=0047. Release `rst`, hold `ins_ready=1`.
  - `ir=4497`, `ins_pc=0`, `ext=0`, `imm=0` after edge 2.
  - `ir=0047`, `ins_pc=1` two cycles later.
- **Two-word instruction.** Redirect to 5, with mem[5]=04E8, mem[6]=0001, mem[7]=6419.
  - `ir=04E8`, `imm=0001`, `ext=1`, `ins_pc=5`.
  - Next instruction: `ins_pc=7`, `ir=6419`.
- **Backpressure.** Hold `ins_ready=0` for 5 cycles while `ins_valid=1`.
  - `ir`, `imm`, `ins_pc` and `eab` stay constant.
  - Accept on the 6th cycle; the next instruction is at `pc+1`.
- **Redirect mid-instruction.** Redirect to 12 during S_EXT of 04E8.
  - 0001 is never presented.
  - Next output: `ir=188C`, `ins_pc=12`.
  - Also check redirect and `ins_ready` in the same cycle: the held instruction is not re-presented.
- **Wrap-around.** Set mem[31]=0008, redirect to 31.
  - `ir=0008`, `imm=mem[0]=4497`, `ins_pc=31`.
  - Next `ins_pc=1`.
- **Bus arbitration and reset.** Assert `mem_busy` for 3 cycles at accept.
  - `ins_valid=0`, `bus_free=1`, `eab` unchanged during the stall.
  - Fetch resumes at the correct PC.
  - Separately, pulse `rst` during S_EXT: all outputs are 0 before the next clock edge, and the fetch restarts from address 0.
